window_loader: RTL and testbench

APB initiator that programs a `window_func` responder from an AXI-Stream coefficient source. On a start pulse it:
- soft-resets the responder FSM;
- writes FFT_SIZE window words to linear addresses 0..(FFT_SIZE-1)*4;
- issues CHANGE STATE;
- polls the status register until the responder reports WAIT.

It sits between a coefficient DMA/ROM stream and the `window_func` APB port, replacing software-driven window setup.

---
 rtl/wfunc_regs_pkg.sv | 32 +++
 rtl/apb_xfer.sv | 50 +++++
 rtl/window_loader.sv | 144 ++++++++++++++
 tb/tb_window_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wfunc_regs_pkg.sv
// rtl/wfunc_regs_pkg.sv - register map and state types shared by window_func and window_loader
package wfunc_regs_pkg;

  localparam int CTRL_CHANGE_STATE_BIT = 8;
  localparam int CTRL_SOFT_RST_BIT     = 0;
  localparam int STAT_STATE_LSB        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BUSY = 2'd2
  } wf_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_WR,
    ST_LOAD,
    ST_FLUSH,
    ST_ARM_WR,
    ST_POLL,
    ST_DONE
  } ld_state_t;

  function automatic int unsigned ctrl_offs(input int unsigned fft_size);
    return fft_size * 4;
  endfunction

  function automatic int unsigned stat_offs(input int unsigned fft_size);
    return (fft_size + 1) * 4;
  endfunction

endpackage

// File: rtl/apb_xfer.sv
// rtl/apb_xfer.sv - single-transfer APB initiator; a req in the access cycle chains the next setup
module apb_xfer #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          write,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          psel,
  output logic          penable,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata
);

  logic launch;

  assign launch = req && (!psel || penable);
  assign ack    = psel && penable;
  assign rdata  = prdata;

  // Address/data only load on launch, so they hold between transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
    end else if (launch) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      paddr   <= addr;
      pwrite  <= write;
      pwdata  <= wdata;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/window_loader.sv
// rtl/window_loader.sv - programs window_func coefficients from a stream over APB
module window_loader #(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1) + 3,
  parameter int POLL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [31:0]       s_tdata,
  input  logic              s_tlast,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);
  import wfunc_regs_pkg::*;

  localparam int KW = $clog2(FFT_SIZE);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(ctrl_offs(FFT_SIZE));
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'(stat_offs(FFT_SIZE));
  localparam logic [KW-1:0]     LAST_K    = KW'(FFT_SIZE - 1);
  localparam logic [PW-1:0]     LAST_POLL = PW'(POLL_MAX - 1);
  localparam logic [31:0]       CMD_SOFT_RST     = 32'(1) << CTRL_SOFT_RST_BIT;
  localparam logic [31:0]       CMD_CHANGE_STATE = 32'(1) << CTRL_CHANGE_STATE_BIT;

  ld_state_t         state, state_nxt;
  logic [KW-1:0]     word_cnt;
  logic [PW-1:0]     poll_cnt;
  logic              req, req_write, ack;
  logic [APB_AW-1:0] req_addr;
  logic [31:0]       req_wdata, rdata;
  logic              accept, word_hs, len_err, poll_retry, poll_to, last_k;
  logic              rdata_unused;

  assign rdata_unused = ^{rdata[31:STAT_STATE_LSB+2], rdata[STAT_STATE_LSB-1:0]};
  assign last_k       = (word_cnt == LAST_K);
  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = (state == ST_DONE);

  apb_xfer #(.AW(APB_AW), .DW(32)) u_xfer (
    .clk(clk), .rst(rst), .req(req), .addr(req_addr), .write(req_write), .wdata(req_wdata),
    .ack(ack), .rdata(rdata), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      poll_cnt <= '0;
      err      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word_cnt <= '0;
        poll_cnt <= '0;
        err      <= '0;
      end
      if (word_hs)    word_cnt <= word_cnt + KW'(1);
      if (len_err)    err[0]   <= 1'b1;
      if (poll_retry) poll_cnt <= poll_cnt + PW'(1);
      if (poll_to)    err[1]   <= 1'b1;
    end
  end

  // Each request is raised in the cycle before its setup so transfers chain back-to-back.
  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    req_addr   = CTRL_ADDR;
    req_write  = 1'b1;
    req_wdata  = CMD_SOFT_RST;
    s_tready   = 1'b0;
    accept     = 1'b0;
    word_hs    = 1'b0;
    len_err    = 1'b0;
    poll_retry = 1'b0;
    poll_to    = 1'b0;
    unique case (state)
      ST_IDLE: if (start) begin
        accept    = 1'b1;
        req       = 1'b1;
        state_nxt = ST_RST_WR;
      end
      ST_RST_WR: if (ack) state_nxt = ST_LOAD;
      ST_LOAD: begin
        s_tready = !psel || penable;
        if (s_tvalid && s_tready) begin
          word_hs   = 1'b1;
          req       = 1'b1;
          req_addr  = APB_AW'({word_cnt, 2'b00});
          req_wdata = s_tdata;
          if (s_tlast || last_k) begin
            len_err   = s_tlast ^ last_k;
            state_nxt = ST_FLUSH;
          end
        end
      end
      // err[0] is already updated here, so it selects abort versus arm.
      ST_FLUSH: if (ack) begin
        if (err[0]) begin
          state_nxt = ST_DONE;
        end else begin
          req       = 1'b1;
          req_wdata = CMD_CHANGE_STATE;
          state_nxt = ST_ARM_WR;
        end
      end
      ST_ARM_WR: if (ack) begin
        req       = 1'b1;
        req_addr  = STAT_ADDR;
        req_write = 1'b0;
        req_wdata = pwdata;
        state_nxt = ST_POLL;
      end
      ST_POLL: if (ack) begin
        if (rdata[STAT_STATE_LSB +: 2] == WAIT) begin
          state_nxt = ST_DONE;
        end else if (poll_cnt == LAST_POLL) begin
          poll_to   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          poll_retry = 1'b1;
          req        = 1'b1;
          req_addr   = STAT_ADDR;
          req_write  = 1'b0;
          req_wdata  = pwdata;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_loader.sv
// tb/tb_window_loader.sv - scenario table plus reset sequence against a transaction-level model
module tb_window_loader;
  localparam int N  = 8;
  localparam int PM = 4;
  localparam int AW = $clog2(N-1) + 3;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0;
  logic s_tvalid, s_tready, s_tlast, psel, penable, pwrite, busy, done;
  logic [31:0] s_tdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic [1:0] err;

  window_loader #(.FFT_SIZE(N), .POLL_MAX(PM)) dut (
    .clk(clk), .rst(rst), .start(start), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [15:0] addr; logic [31:0] data; } xfer_t;
  typedef struct { int tlast_at; int n_fail; bit gaps; bit mid_start; bit rnd_data;
                   logic [1:0] exp_err; int exp_done; } scen_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0 = 0, scen_id = 0, n_fail = 0;
  int mon_scen = -1, rd_cnt = 0, done_cnt = 0, done_at = -1;
  int drv_scen = -1, strm_idx = 0, strm_len = 0, exp_n = 0;
  bit strm_en = 0, gaps = 0, hs = 0;
  logic [31:0] strm_data [16];
  bit          strm_last [16];
  logic [31:0] prdata_v = 32'h0;
  xfer_t log_q[$];
  xfer_t exp_q[$];
  scen_t tbl[7];

  assign prdata = prdata_v;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: logs completed transfers, answers status reads by read count.
  always @(negedge clk) begin
    if (scen_id != mon_scen) begin
      mon_scen = scen_id; log_q.delete(); rd_cnt = 0; done_cnt = 0; done_at = -1;
    end
    if (psel && !penable && !pwrite) begin
      prdata_v = (rd_cnt < n_fail) ? 32'h0 : 32'h100;
      rd_cnt++;
    end
    if (psel && penable) log_q.push_back(xfer_t'({pwrite, 16'(paddr), pwrite ? pwdata : prdata}));
    if (done) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc - t0;
    end
  end

  initial begin
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_scen != scen_id) begin drv_scen = scen_id; strm_idx = 0; end
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs && !rst) strm_idx++;
      s_tvalid = strm_en && (strm_idx < strm_len) && (!gaps || $urandom_range(0, 1) == 1);
      s_tdata  = strm_data[strm_idx % 16];
      s_tlast  = strm_last[strm_idx % 16];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the ordered APB traffic implied by the stream contents and status answers.
  task automatic build_exp();
    bit ok = 0;
    int r;
    exp_q.delete(); exp_n = 0;
    exp_q.push_back(xfer_t'({1'b1, 16'(N*4), 32'h1}));
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(xfer_t'({1'b1, 16'(k*4), strm_data[k]}));
      exp_n++;
      if (strm_last[k] || k == N-1) begin ok = strm_last[k] && (k == N-1); break; end
    end
    if (ok) begin
      exp_q.push_back(xfer_t'({1'b1, 16'(N*4), 32'h100}));
      r = (n_fail + 1 < PM) ? n_fail + 1 : PM;
      for (int i = 0; i < r; i++)
        exp_q.push_back(xfer_t'({1'b0, 16'((N+1)*4), (i < n_fail) ? 32'h0 : 32'h100}));
    end
  endtask

  task automatic run(input int idx);
    scen_t s = tbl[idx];
    scen_id++;
    n_fail = s.n_fail; gaps = s.gaps; strm_len = 12; strm_en = 1;
    for (int k = 0; k < 16; k++) begin
      strm_data[k] = s.rnd_data ? $urandom : 32'h0001_0000 + k;
      strm_last[k] = (k == s.tlast_at);
    end
    build_exp();
    repeat (2) @(negedge clk);
    @(posedge clk); #1; start = 1'b1; t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk($sformatf("s%0d_busy_c1", idx), busy, 1);
    for (int c = 0; c < 400; c++) begin
      if (done_cnt > 0) break;
      if (s.mid_start && c == 12) begin
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("s%0d_done_seen", idx), done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    chk($sformatf("s%0d_done_pulses", idx), done_cnt, 1);
    chk($sformatf("s%0d_err", idx), err, s.exp_err);
    chk($sformatf("s%0d_idle_busy", idx), busy, 0);
    chk($sformatf("s%0d_idle_tready", idx), s_tready, 0);
    chk($sformatf("s%0d_consumed", idx), strm_idx, exp_n);
    if (s.exp_done >= 0) chk($sformatf("s%0d_done_cycle", idx), done_at, s.exp_done);
    chk($sformatf("s%0d_xfer_count", idx), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("s%0d_xfer%0d", idx, i), log_q[i], exp_q[i]);
  endtask

  initial begin
    tbl[0] = '{7,  0, 0, 0, 0, 2'b00, 24};
    tbl[1] = '{4,  0, 0, 0, 0, 2'b01, 14};
    tbl[2] = '{-1, 0, 0, 0, 0, 2'b01, 20};
    tbl[3] = '{7,  3, 0, 0, 0, 2'b00, 30};
    tbl[4] = '{7, 99, 0, 0, 0, 2'b10, 30};
    tbl[5] = '{7,  0, 1, 1, 1, 2'b00, -1};
    tbl[6] = '{7,  1, 0, 0, 1, 2'b00, 26};

    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_err", err, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_paddr_pwdata", {pwrite, 16'(paddr), pwdata}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run(i);

    // Reset during the access cycle of word 3, then a full replay.
    scen_id++;
    n_fail = 0; gaps = 0; strm_len = 12; strm_en = 1;
    for (int k = 0; k < 16; k++) begin
      strm_data[k] = 32'h0001_0000 + k;
      strm_last[k] = (k == 7);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1; start = 1'b1; t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    begin
      bit found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
        @(negedge clk);
        found = psel && penable && pwrite && (paddr == AW'(12));
      end
      chk("rstmid_reached_word3", found, 1);
    end
    #1; rst = 1'b1; #1;
    chk("rstmid_psel", psel, 0);
    chk("rstmid_penable", penable, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_tready", s_tready, 0);
    @(negedge clk); rst = 1'b0;
    run(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
